// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with a 2-bit saturating counter per entry.
// Lookup is combinational on fetch_pc; updates from execute are registered.

package branch_predictor_pkg;
    typedef enum logic {
        PC_NEXT   = 1'b0,
        PC_BRANCH = 1'b1
    } pc_branch_mux_t;
endpackage

module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int AddrWidth = 32,
    parameter int Entries   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [AddrWidth-1:0] fetch_pc,
    output pc_branch_mux_t       pred_sel,
    output logic [AddrWidth-1:0] pred_target,
    input  logic                 upd_valid,
    input  logic [AddrWidth-1:0] upd_pc,
    input  logic                 upd_taken,
    input  logic [AddrWidth-1:0] upd_target
);

    localparam int IdxBits = $clog2(Entries);
    localparam int TagBits = AddrWidth - 2 - IdxBits;

    logic [Entries-1:0]   valid_q;
    logic [TagBits-1:0]   tag_q    [Entries];
    logic [AddrWidth-1:0] target_q [Entries];
    logic [1:0]           ctr_q    [Entries];

    logic [IdxBits-1:0] fetch_idx;
    logic [TagBits-1:0] fetch_tag;
    logic [IdxBits-1:0] upd_idx;
    logic [TagBits-1:0] upd_tag;
    logic               fetch_hit;
    logic               upd_hit;
    logic [1:0]         upd_ctr;

    assign fetch_idx = fetch_pc[IdxBits+1:2];
    assign fetch_tag = fetch_pc[AddrWidth-1:IdxBits+2];
    assign upd_idx   = upd_pc[IdxBits+1:2];
    assign upd_tag   = upd_pc[AddrWidth-1:IdxBits+2];

    // Instructions are word aligned, so the byte-offset bits never take part in addressing.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

    assign fetch_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_ctr   = ctr_q[upd_idx];

    always_comb begin
        pred_sel    = PC_NEXT;
        pred_target = '0;
        if (fetch_hit && ctr_q[fetch_idx][1]) begin
            pred_sel    = PC_BRANCH;
            pred_target = target_q[fetch_idx];
        end
    end

    // Lookup reads these registers directly, so a same-cycle update is only seen next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < Entries; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (flush) begin
            valid_q <= '0;
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    ctr_q[upd_idx]    <= (upd_ctr == 2'b11) ? 2'b11 : upd_ctr + 2'd1;
                    target_q[upd_idx] <= upd_target;
                end else begin
                    ctr_q[upd_idx] <= (upd_ctr == 2'b00) ? 2'b00 : upd_ctr - 2'd1;
                end
            end else if (upd_taken) begin
                // Misses (including tag aliases) allocate only on a taken outcome, weakly taken.
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target;
                ctr_q[upd_idx]    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor; each vector is one clock cycle and
// checks the combinational prediction before that cycle's edge.

module tb_branch_predictor;
    import branch_predictor_pkg::*;

    logic           clk;
    logic           reset;
    logic           flush;
    logic [31:0]    fetch_pc;
    pc_branch_mux_t pred_sel;
    logic [31:0]    pred_target;
    logic           upd_valid;
    logic [31:0]    upd_pc;
    logic           upd_taken;
    logic [31:0]    upd_target;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic           rst;
        logic           fl;
        logic           uv;
        logic [31:0]    upc;
        logic           ut;
        logic [31:0]    utgt;
        logic [31:0]    fpc;
        pc_branch_mux_t esel;
        logic [31:0]    etgt;
    } vec_t;

    vec_t vecs[$];

    branch_predictor #(.AddrWidth(32), .Entries(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .fetch_pc    (fetch_pc),
        .pred_sel    (pred_sel),
        .pred_target (pred_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic rst, logic fl, logic uv, logic [31:0] upc, logic ut,
                                logic [31:0] utgt, logic [31:0] fpc, pc_branch_mux_t esel,
                                logic [31:0] etgt);
        vec_t v;
        v.rst = rst; v.fl = fl; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
        v.fpc = fpc; v.esel = esel; v.etgt = etgt;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        reset      = v.rst;
        flush      = v.fl;
        upd_valid  = v.uv;
        upd_pc     = v.upc;
        upd_taken  = v.ut;
        upd_target = v.utgt;
        fetch_pc   = v.fpc;
    endtask

    task automatic checkOutput(input string name, input pc_branch_mux_t esel, input logic [31:0] etgt);
        tests_run++;
        if (pred_sel !== esel || pred_target !== etgt) begin
            tests_failed++;
            $display("[TB] FAIL %s: got sel=%0d target=0x%08h, expected sel=%0d target=0x%08h",
                     name, pred_sel, pred_target, esel, etgt);
        end
    endtask

    initial begin
        // Lookup after reset
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,       32'h100, PC_NEXT,   32'h0));
        // First allocation, visible next cycle; neighbouring PC misses
        vecs.push_back(mk(0,0,1,32'h100,1,32'h200,   32'h104, PC_NEXT,   32'h0));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,       32'h100, PC_BRANCH, 32'h200));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,       32'h104, PC_NEXT,   32'h0));
        // Counter walk: 10 -> 01 -> 00 -> 01 -> 10 -> 11 -> 11 -> 10
        vecs.push_back(mk(0,0,1,32'h100,0,32'h0,     32'h100, PC_BRANCH, 32'h200));
        vecs.push_back(mk(0,0,1,32'h100,0,32'h0,     32'h100, PC_NEXT,   32'h0));
        vecs.push_back(mk(0,0,1,32'h100,1,32'h200,   32'h100, PC_NEXT,   32'h0));
        vecs.push_back(mk(0,0,1,32'h100,1,32'h200,   32'h100, PC_NEXT,   32'h0));
        vecs.push_back(mk(0,0,1,32'h100,1,32'h300,   32'h100, PC_BRANCH, 32'h200));
        vecs.push_back(mk(0,0,1,32'h100,1,32'h300,   32'h100, PC_BRANCH, 32'h300));
        vecs.push_back(mk(0,0,1,32'h100,0,32'h0,     32'h100, PC_BRANCH, 32'h300));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,       32'h100, PC_BRANCH, 32'h300));
        // Alias at idx 0: 0x140 replaces 0x100; not-taken 0x180 leaves it alone
        vecs.push_back(mk(0,0,1,32'h140,1,32'h440,   32'h100, PC_BRANCH, 32'h300));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,       32'h100, PC_NEXT,   32'h0));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,       32'h140, PC_BRANCH, 32'h440));
        vecs.push_back(mk(0,0,1,32'h180,0,32'h0,     32'h180, PC_NEXT,   32'h0));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,       32'h140, PC_BRANCH, 32'h440));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,       32'h180, PC_NEXT,   32'h0));
        // Same-cycle update and lookup reads the old state
        vecs.push_back(mk(0,0,1,32'h208,1,32'h1234,  32'h208, PC_NEXT,   32'h0));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,       32'h208, PC_BRANCH, 32'h1234));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,       32'h140, PC_BRANCH, 32'h440));
        // Flush wins over a simultaneous update
        vecs.push_back(mk(0,1,1,32'h300,1,32'h999,   32'h208, PC_BRANCH, 32'h1234));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,       32'h208, PC_NEXT,   32'h0));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,       32'h140, PC_NEXT,   32'h0));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,       32'h300, PC_NEXT,   32'h0));
        // Rebuild, then reset during an update stream
        vecs.push_back(mk(0,0,1,32'h100,1,32'h500,   32'h100, PC_NEXT,   32'h0));
        vecs.push_back(mk(0,0,1,32'h20C,1,32'h600,   32'h100, PC_BRANCH, 32'h500));
        vecs.push_back(mk(1,0,1,32'h210,1,32'h700,   32'h20C, PC_BRANCH, 32'h600));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,       32'h20C, PC_NEXT,   32'h0));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,       32'h100, PC_NEXT,   32'h0));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,       32'h210, PC_NEXT,   32'h0));
        // Normal allocation resumes after reset
        vecs.push_back(mk(0,0,1,32'h100,1,32'h800,   32'h100, PC_NEXT,   32'h0));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,       32'h100, PC_BRANCH, 32'h800));

        reset      = 1'b1;
        flush      = 1'b0;
        upd_valid  = 1'b0;
        upd_pc     = '0;
        upd_taken  = 1'b0;
        upd_target = '0;
        fetch_pc   = 32'h100;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d", i), vecs[i].esel, vecs[i].etgt);
        end

        // Reset held across several cycles of taken updates allocates nothing
        @(negedge clk);
        reset = 1'b1; upd_valid = 1'b1; upd_taken = 1'b1;
        for (int k = 0; k < 3; k++) begin
            upd_pc     = 32'h400 + 32'(k * 4);
            upd_target = 32'hA00 + 32'(k * 16);
            fetch_pc   = 32'h400;
            @(negedge clk);
        end
        reset = 1'b0; upd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            fetch_pc = 32'h400 + 32'(k * 4);
            #1;
            checkOutput($sformatf("held_reset_%0d", k), PC_NEXT, 32'h0);
            @(negedge clk);
        end
        fetch_pc = 32'h100;
        #1;
        checkOutput("held_reset_old", PC_NEXT, 32'h0);

        // Flush held while an alias stream runs, then a single update is accepted
        @(negedge clk);
        flush = 1'b1; upd_valid = 1'b1; upd_taken = 1'b1;
        upd_pc = 32'h140; upd_target = 32'hBEEC;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b0;
        fetch_pc = 32'h140;
        #1;
        checkOutput("flush_held", PC_NEXT, 32'h0);
        @(negedge clk);
        upd_valid = 1'b0;
        #1;
        checkOutput("after_flush_update", PC_BRANCH, 32'hBEEC);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
